// File: rtl/writeback_if.sv
// writeback_if: MEM-to-writeback handshake, load-data return and register-file write bundle
interface writeback_if #(parameter int CNT_W = 32);
  logic             in_valid;
  logic             in_ready;
  logic             in_reg_write;
  logic [4:0]       in_rd;
  logic [1:0]       in_result_src;
  logic [31:0]      in_alu_result;
  logic [31:0]      in_pc_plus4;
  logic [2:0]       in_funct3;
  logic             mem_rvalid;
  logic [31:0]      mem_rdata;
  logic             we3;
  logic [4:0]       a3;
  logic [31:0]      wd3;
  logic [CNT_W-1:0] instret;
  modport master (
    output in_valid, in_reg_write, in_rd, in_result_src, in_alu_result, in_pc_plus4, in_funct3,
           mem_rvalid, mem_rdata,
    input  in_ready, we3, a3, wd3, instret
  );
  modport slave (
    input  in_valid, in_reg_write, in_rd, in_result_src, in_alu_result, in_pc_plus4, in_funct3,
           mem_rvalid, mem_rdata,
    output in_ready, we3, a3, wd3, instret
  );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: captures one retiring instruction, waits for load data, commits for one cycle
module writeback_stage #(
  parameter int CNT_W = 32
) (
  input logic         clock,
  input logic         reset,
  writeback_if.slave  bus
);
  typedef enum logic [1:0] {EMPTY, WAIT_LOAD, FULL} state_t;
  state_t           state_q;
  logic [4:0]       rd_q;
  logic             rw_q;
  logic [31:0]      data_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [CNT_W-1:0] instret_q;
  logic             accept;
  logic [7:0]       byte_w;
  logic [15:0]      half_w;
  logic [31:0]      ld_data;
  assign bus.in_ready = !reset && state_q != WAIT_LOAD;
  assign accept       = bus.in_valid && bus.in_ready;
  assign byte_w       = bus.mem_rdata[{off_q, 3'b000} +: 8];
  assign half_w       = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
  // Unlisted funct3 codes return the word untouched.
  always_comb
    ld_data = f3_q == 3'b000 ? {{24{byte_w[7]}}, byte_w} :
              f3_q == 3'b001 ? {{16{half_w[15]}}, half_w} :
              f3_q == 3'b100 ? {24'b0, byte_w} :
              f3_q == 3'b101 ? {16'b0, half_w} : bus.mem_rdata;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= EMPTY;
      rd_q      <= '0;
      rw_q      <= 1'b0;
      data_q    <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      instret_q <= '0;
    end else begin
      if (state_q == FULL) instret_q <= instret_q + CNT_W'(1);
      if (accept) begin
        rd_q <= bus.in_rd;
        rw_q <= bus.in_reg_write;
        if (bus.in_result_src == 2'b01) begin
          f3_q    <= bus.in_funct3;
          off_q   <= bus.in_alu_result[1:0];
          state_q <= WAIT_LOAD;
        end else begin
          data_q  <= bus.in_result_src == 2'b10 ? bus.in_pc_plus4 : bus.in_alu_result;
          state_q <= FULL;
        end
      end else if (state_q == WAIT_LOAD && bus.mem_rvalid) begin
        data_q  <= ld_data;
        state_q <= FULL;
      end else if (state_q == FULL) begin
        state_q <= EMPTY;
      end
    end
  end
  assign bus.we3     = state_q == FULL && rw_q && rd_q != 5'd0;
  assign bus.a3      = rd_q;
  assign bus.wd3     = data_q;
  assign bus.instret = instret_q;
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed scenarios plus random traffic against a behavioural model
module tb_writeback_stage;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;
  writeback_if #(.CNT_W(32)) bus ();
  writeback_stage #(.CNT_W(32)) dut (.clock(clock), .reset(reset), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  // model: a load in flight, a commit showing this cycle, the last captured fields, retire count
  bit          m_wait, m_commit, m_rw;
  bit [4:0]    m_rd;
  bit [31:0]   m_data, m_count, m_addr;
  bit [2:0]    m_f3;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit [31:0] load_ext(input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] w);
    bit [31:0] b, h;
    b = (w >> (8 * (addr % 4))) & 32'hFF;
    h = (w >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
    case (f3)
      3'd0: return b >= 128 ? b + 32'hFFFFFF00 : b;
      3'd1: return h >= 32768 ? h + 32'hFFFF0000 : h;
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction
  task automatic cyc(input bit v, input bit rw, input bit [4:0] rd, input bit [1:0] src,
                     input bit [31:0] alu, input bit [31:0] pc4, input bit [2:0] f3,
                     input bit rv, input bit [31:0] rdata, input bit rst);
    bit nxt;
    reset = rst;
    bus.in_valid = v; bus.in_reg_write = rw; bus.in_rd = rd; bus.in_result_src = src;
    bus.in_alu_result = alu; bus.in_pc_plus4 = pc4; bus.in_funct3 = f3;
    bus.mem_rvalid = rv; bus.mem_rdata = rdata;
    @(posedge clock);
    if (rst) begin
      m_wait = 0; m_commit = 0; m_rw = 0; m_rd = 0; m_data = 0; m_count = 0;
    end else begin
      if (m_commit) m_count++;
      nxt = 0;
      if (v && !m_wait) begin
        m_rd = rd; m_rw = rw;
        if (src == 2'b01) begin
          m_wait = 1; m_f3 = f3; m_addr = alu;
        end else begin
          m_data = (src == 2'b10) ? pc4 : alu;
          nxt = 1;
        end
      end else if (m_wait && rv) begin
        m_data = load_ext(m_f3, m_addr, rdata);
        m_wait = 0;
        nxt = 1;
      end
      m_commit = nxt;
    end
    @(negedge clock);
    check("in_ready", bus.in_ready, !reset && !m_wait);
    check("we3", bus.we3, m_commit && m_rw && m_rd != 0);
    check("a3", bus.a3, m_rd);
    check("wd3", bus.wd3, m_data);
    check("instret", bus.instret, m_count);
  endtask
  task automatic idle(input bit rv = 0, input bit [31:0] rdata = 0);
    cyc(0, 0, 0, 0, 0, 0, 0, rv, rdata, 0);
  endtask
  initial begin
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 9, 0, 32'hDEAD, 0, 0, 1, 0, 1);
    check("rst_instret", bus.instret, 0);
    check("rst_we3", bus.we3, 0);
    // single ALU op
    cyc(1, 1, 5, 0, 32'h12345678, 0, 0, 0, 0, 0);
    check("alu_wd3", bus.wd3, 32'h12345678);
    check("alu_we3", bus.we3, 1);
    idle();
    check("alu_instret", bus.instret, 1);
    // back-to-back ALU ops
    cyc(1, 1, 1, 0, 32'h11, 0, 0, 0, 0, 0);
    cyc(1, 1, 2, 3, 32'h22, 32'h99, 0, 0, 0, 0);
    check("b2b_a3", bus.a3, 2);
    check("b2b_wd3", bus.wd3, 32'h22);
    idle();
    // LB at offset 3 after three wait cycles; rvalid on the accepting edge is ignored
    cyc(1, 1, 7, 1, 32'h1003, 0, 3'b000, 1, 32'h7F7F7F7F, 0);
    repeat (3) idle();
    check("lb_wait_ready", bus.in_ready, 0);
    idle(1, 32'h80FF00AA);
    check("lb_wd3", bus.wd3, 32'hFFFFFF80);
    check("lb_we3", bus.we3, 1);
    idle(1, 32'h0);
    check("lb_we3_drop", bus.we3, 0);
    // LHU / LH at offset 2
    cyc(1, 1, 3, 1, 32'h2002, 0, 3'b101, 0, 0, 0);
    idle(1, 32'hBEEF1234);
    check("lhu_wd3", bus.wd3, 32'h0000BEEF);
    cyc(1, 1, 3, 1, 32'h2003, 0, 3'b001, 0, 0, 0);
    idle(1, 32'hBEEF1234);
    check("lh_wd3", bus.wd3, 32'hFFFFBEEF);
    // writes suppressed but still retired
    cyc(1, 1, 0, 0, 32'h55, 0, 0, 0, 0, 0);
    check("rd0_we3", bus.we3, 0);
    cyc(1, 0, 4, 2, 0, 32'h104, 0, 0, 0, 0);
    check("norw_we3", bus.we3, 0);
    idle();
    // reset while waiting for load data
    cyc(1, 1, 6, 1, 32'h3000, 0, 3'b010, 0, 0, 0);
    idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE, 1);
    idle(1, 32'hCAFE);
    check("rstw_we3", bus.we3, 0);
    check("rstw_ready", bus.in_ready, 1);
    check("rstw_instret", bus.instret, 0);
    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom % 4 != 0, 1'($urandom), 5'($urandom), 2'($urandom), $urandom, $urandom,
          3'($urandom), $urandom % 3 == 0, $urandom, $urandom % 150 == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
